lift_request_scheduler: RTL and testbench

LIFT_REQUEST_SCHEDULER -- requirements
Module: lift_request_scheduler

---
 rtl/lift_pkg.sv | 14 +
 rtl/lift_nearest_pick.sv | 36 +++
 rtl/lift_request_scheduler.sv | 152 +++++++++++++++
 tb/tb_lift_request_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared lift definitions: floor count, floor index width and the
// scheduler state encoding, reused by the scheduler and the mover.
package lift_pkg;

    localparam int NUM_FLOORS = 15;
    localparam int FLOOR_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } lift_state_t;

endpackage

// File: rtl/lift_nearest_pick.sv
// Combinational search for the closest pending floor at or beyond the
// current floor in the given direction (dir = 1 searches upward).
module lift_nearest_pick
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = lift_pkg::NUM_FLOORS
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  dir,
    output logic                  found,
    output logic [FLOOR_W-1:0]    nearest
);

    // Scan away from the search direction so the last hit is the closest one.
    always_comb begin
        found   = 1'b0;
        nearest = floor;
        if (dir) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (pending[i] && (i >= int'(floor))) begin
                    found   = 1'b1;
                    nearest = FLOOR_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (pending[i] && (i <= int'(floor))) begin
                    found   = 1'b1;
                    nearest = FLOOR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/lift_request_scheduler.sv
// Collects call-button requests into a pending bitmap and steers the mover
// floor by floor, keeping direction until nothing is left that way.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = lift_pkg::NUM_FLOORS,
    parameter int DOOR_TICKS = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_set,
    input  logic [FLOOR_W-1:0]    sw,
    input  logic [FLOOR_W-1:0]    floor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open,
    output lift_state_t           state_dbg
);

    localparam int DWELL_W = $clog2(DOOR_TICKS + 1);
    localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DOOR_TICKS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE_HOT0   = NUM_FLOORS'(1);

    lift_state_t           state, state_n;
    logic [FLOOR_W-1:0]    target_n;
    logic [NUM_FLOORS-1:0] pending_n, set_mask, clr_mask, floor_mask, sw_mask;
    logic                  dir_n;
    logic [DWELL_W-1:0]    dwell, dwell_n;

    logic       btn_meta, btn_sync, btn_prev, armed;
    logic [1:0] prime;
    logic       set_pulse, floor_ok, sw_ok, at_call;
    logic       fwd_found, rev_found;
    logic [FLOOR_W-1:0] fwd_floor, rev_floor;

    // The button must be seen released after the synchronizer has refilled
    // out of reset before any edge counts, so a held button is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            prime    <= 2'b00;
            armed    <= 1'b0;
        end else begin
            btn_meta <= btn_set;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            prime    <= {prime[0], 1'b1};
            armed    <= armed | (prime[1] & ~btn_sync);
        end
    end

    assign set_pulse  = armed & btn_sync & ~btn_prev;
    assign floor_ok   = int'(floor) < NUM_FLOORS;
    assign sw_ok      = int'(sw) < NUM_FLOORS;
    assign floor_mask = floor_ok ? (ONE_HOT0 << floor) : '0;
    assign sw_mask    = sw_ok ? (ONE_HOT0 << sw) : '0;
    assign at_call    = |(pending & floor_mask);

    lift_nearest_pick #(.NUM_FLOORS(NUM_FLOORS)) u_pick_fwd (
        .pending (pending),
        .floor   (floor),
        .dir     (dir_up),
        .found   (fwd_found),
        .nearest (fwd_floor)
    );

    lift_nearest_pick #(.NUM_FLOORS(NUM_FLOORS)) u_pick_rev (
        .pending (pending),
        .floor   (floor),
        .dir     (~dir_up),
        .found   (rev_found),
        .nearest (rev_floor)
    );

    always_comb begin
        state_n  = state;
        target_n = target_floor;
        dir_n    = dir_up;
        dwell_n  = dwell;
        clr_mask = '0;
        set_mask = set_pulse ? sw_mask : '0;
        case (state)
            ST_IDLE: begin
                if (at_call) begin
                    clr_mask = floor_mask;
                    target_n = floor;
                    dwell_n  = '0;
                    state_n  = ST_DOOR;
                end else if (fwd_found) begin
                    target_n = fwd_floor;
                    state_n  = ST_MOVING;
                end else if (rev_found) begin
                    dir_n    = ~dir_up;
                    target_n = rev_floor;
                    state_n  = ST_MOVING;
                end else if (floor_ok) begin
                    target_n = floor;
                end
            end
            ST_MOVING: begin
                // Direction is frozen here; only IDLE may turn the car round.
                if (at_call) begin
                    clr_mask = floor_mask;
                    target_n = floor;
                    dwell_n  = '0;
                    state_n  = ST_DOOR;
                end else if (fwd_found) begin
                    target_n = fwd_floor;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DOOR: begin
                if (floor_ok) target_n = floor;
                if (set_pulse && (sw == floor)) begin
                    set_mask = '0;
                    dwell_n  = '0;
                end else if (dwell == DWELL_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        pending_n = (pending | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pending      <= '0;
            target_floor <= '0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            dwell        <= '0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            target_floor <= target_n;
            dir_up       <= dir_n;
            door_open    <= (state_n == ST_DOOR);
            dwell        <= dwell_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Directed bench for lift_request_scheduler with a 3-cycle-per-floor mover
// model and a queue of expected door-open floors.
module tb_lift_request_scheduler;
    import lift_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_set = 1'b0;
    logic [3:0]  sw = 4'd0;
    wire  [3:0]  floor;
    logic [3:0]  target_floor;
    logic [14:0] pending;
    logic        dir_up;
    logic        door_open;
    lift_state_t state_dbg;

    logic [3:0]  manual_floor = 4'd0;
    logic        mv_manual = 1'b1;
    logic [3:0]  mover_floor = 4'd0;
    int          mv_cnt = 0;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [3:0]  exp_q[$];

    lift_request_scheduler #(.NUM_FLOORS(15), .DOOR_TICKS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_set      (btn_set),
        .sw           (sw),
        .floor        (floor),
        .target_floor (target_floor),
        .pending      (pending),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // mover model: one floor step toward target_floor every 3 cycles
    assign floor = mv_manual ? manual_floor : mover_floor;

    always @(negedge clk) begin
        if (mv_manual || rst) begin
            if (mv_manual) mover_floor = manual_floor;
            mv_cnt = 0;
        end else if (mover_floor != target_floor) begin
            if (mv_cnt == 2) begin
                mv_cnt = 0;
                mover_floor = (target_floor > mover_floor) ? mover_floor + 4'd1
                                                           : mover_floor - 4'd1;
            end else begin
                mv_cnt++;
            end
        end else begin
            mv_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic apply_reset(input logic [3:0] f);
        manual_floor = f;
        mv_manual    = 1'b1;
        btn_set      = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] f);
        @(negedge clk);
        sw      = f;
        btn_set = 1'b1;
        repeat (2) @(negedge clk);
        btn_set = 1'b0;
    endtask

    // scoreboard: each door opening must match the next expected floor
    task automatic wait_door(input int budget, output int len);
        int n;
        n   = 0;
        len = 0;
        while (!door_open && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!door_open) begin
            check("door_timeout", 32'(door_open), 32'd1);
        end else begin
            if (exp_q.size() == 0) check("door_extra", 32'(floor), 32'hff);
            else check("door_floor", 32'(floor), 32'(exp_q.pop_front()));
            while (door_open && len < 50) begin
                len++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int len;
        int n;

        // reset values
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_target", 32'(target_floor), 32'h0);
        check("rst_dir", 32'(dir_up), 32'h1);
        check("rst_door", 32'(door_open), 32'h0);

        // single call from floor 0 to floor 5
        apply_reset(4'd0);
        mv_manual = 1'b0;
        exp_q.push_back(4'd5);
        press(4'd5);
        @(negedge clk);
        check("t1_pending", 32'(pending), 32'h0020);
        @(negedge clk);
        check("t1_state", 32'(state_dbg), 32'(ST_MOVING));
        check("t1_target", 32'(target_floor), 32'd5);
        wait_door(100, len);
        check("t1_door_len", 32'(len), 32'd4);
        check("t1_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("t1_cleared", 32'(pending), 32'h0);

        // in-path call becomes an intermediate stop
        apply_reset(4'd0);
        mv_manual = 1'b0;
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd9);
        press(4'd9);
        n = 0;
        while (floor != 4'd2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t2_reach2", 32'(floor), 32'd2);
        press(4'd4);
        n = 0;
        while (target_floor != 4'd4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t2_mid_target", 32'(target_floor), 32'd4);
        wait_door(60, len);
        check("t2_door4_len", 32'(len), 32'd4);
        wait_door(100, len);
        check("t2_door9_len", 32'(len), 32'd4);

        // idle at 6 going up with calls at 2 and 10: 10 first, then reverse
        apply_reset(4'd4);
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd10);
        exp_q.push_back(4'd2);
        press(4'd6);
        press(4'd10);
        press(4'd2);
        repeat (2) @(negedge clk);
        check("t3_pending", 32'(pending), 32'h0444);
        check("t3_target", 32'(target_floor), 32'd6);
        check("t3_dir", 32'(dir_up), 32'd1);
        mv_manual = 1'b0;
        wait_door(60, len);
        wait_door(100, len);
        @(negedge clk);
        check("t3_dir_flip", 32'(dir_up), 32'd0);
        check("t3_target2", 32'(target_floor), 32'd2);
        wait_door(150, len);

        // out-of-range call ignored; top floor accepted
        manual_floor = floor;
        mv_manual    = 1'b1;
        press(4'd15);
        repeat (3) @(negedge clk);
        check("t4_ignore_pending", 32'(pending), 32'h0);
        check("t4_ignore_state", 32'(state_dbg), 32'(ST_IDLE));
        check("t4_ignore_target", 32'(target_floor), 32'd2);
        press(4'd14);
        @(negedge clk);
        check("t4_top_pending", 32'(pending), 32'h4000);

        // same-floor call while door is open restarts the dwell
        apply_reset(4'd3);
        press(4'd3);
        @(negedge clk);
        check("t5_pending_set", 32'(pending), 32'h0008);
        @(negedge clk);
        check("t5_door", 32'(door_open), 32'd1);
        check("t5_cleared", 32'(pending), 32'h0);
        sw      = 4'd3;
        btn_set = 1'b1;
        len = 0;
        for (int k = 0; k < 20; k++) begin
            if (!door_open) break;
            len++;
            if (k == 3) btn_set = 1'b0;
            @(negedge clk);
        end
        btn_set = 1'b0;
        check("t5_door_len", 32'(len), 32'd7);
        check("t5_pending", 32'(pending), 32'h0);
        check("t5_idle", 32'(state_dbg), 32'(ST_IDLE));

        // reset mid-move discards calls; held button gives no call
        apply_reset(4'd5);
        press(4'd8);
        press(4'd12);
        repeat (2) @(negedge clk);
        check("t6_pending", 32'(pending), 32'h1100);
        check("t6_target", 32'(target_floor), 32'd8);
        check("t6_moving", 32'(state_dbg), 32'(ST_MOVING));
        mv_manual = 1'b0;
        repeat (4) @(negedge clk);
        sw      = 4'd3;
        btn_set = 1'b1;
        rst     = 1'b1;
        #1;
        check("t6_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("t6_rst_pending", 32'(pending), 32'h0);
        check("t6_rst_target", 32'(target_floor), 32'h0);
        check("t6_rst_dir", 32'(dir_up), 32'h1);
        check("t6_rst_door", 32'(door_open), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_held_pending", 32'(pending), 32'h0);
        check("t6_held_state", 32'(state_dbg), 32'(ST_IDLE));
        check("t6_hold_target", 32'(target_floor), 32'(floor));
        btn_set = 1'b0;

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
